// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: double-buffers digit patterns,
// swaps them in at frame boundaries and scans digits with a blanking gap.
module seg_scan_ctrl #(
    parameter int SCAN_DIV      = 100000,
    parameter int BLANK_CYC     = 1000,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] cx1,
    input  logic [6:0] cx2,
    input  logic [6:0] cx3,
    input  logic [6:0] cx4,
    input  logic       hi,
    input  logic [3:0] dig_en,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       load_ack,
    output logic       upd_pend,
    output logic       frame_done
);

    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [3:0]    AN_OFF    = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [6:0]    disp   [4];
    logic [6:0]    shadow [4];
    logic [6:0]    cx_in  [4];
    logic [6:0]    seg_r;
    logic [3:0]    an_sel;
    logic [3:0]    an_next;
    logic          boundary;
    logic          drive;

    always_comb begin
        cx_in[0] = cx1;
        cx_in[1] = cx2;
        cx_in[2] = cx3;
        cx_in[3] = cx4;
    end

    assign boundary = (idx == 2'd3) && (cnt == CNT_LAST);
    assign drive    = (cnt >= CNT_BLANK);

    always_comb begin
        an_sel = 4'b0000;
        if (drive && dig_en[idx]) begin
            an_sel[idx] = 1'b1;
        end
        an_next = (AN_ACTIVE_LOW != 0) ? ~an_sel : an_sel;
    end

    // Slot counter and digit index free-run; idx wraps naturally at 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load coinciding with the boundary bypasses the shadow so the new
    // pattern still lands in the very next frame with nothing left pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                disp[i]   <= '0;
                shadow[i] <= '0;
            end
            upd_pend <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= load;
            if (load) begin
                for (int i = 0; i < 4; i++) begin
                    shadow[i] <= cx_in[i];
                end
            end
            if (boundary && load) begin
                for (int i = 0; i < 4; i++) begin
                    disp[i] <= cx_in[i];
                end
                upd_pend <= 1'b0;
            end else if (boundary) begin
                if (upd_pend) begin
                    for (int i = 0; i < 4; i++) begin
                        disp[i] <= shadow[i];
                    end
                end
                upd_pend <= 1'b0;
            end else if (load) begin
                upd_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r      <= '0;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg_r      <= drive ? disp[idx] : 7'h00;
            an         <= an_next;
            frame_done <= boundary;
        end
    end

    // Polarity is applied after the register so hi acts in the same cycle.
    assign seg = seg_r ^ {7{~hi}};

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_seg_scan_ctrl;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load;
    logic [6:0] cx1, cx2, cx3, cx4;
    logic       hi;
    logic [3:0] dig_en;
    logic [6:0] seg;
    logic [3:0] an;
    logic       load_ack, upd_pend, frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit started = 1'b0;

    int          lq_cyc [$];
    logic [27:0] lq_val [$];
    logic [3:0]  dig_hist [2048];

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .load(load),
        .cx1(cx1), .cx2(cx2), .cx3(cx3), .cx4(cx4),
        .hi(hi), .dig_en(dig_en),
        .seg(seg), .an(an), .load_ack(load_ack),
        .upd_pend(upd_pend), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t cyc=%0d: got %0h, expected %0h", name, $time, cyc, act, exp);
        end
    endtask

    // Pattern shown in frame f: the latest load captured in any earlier frame.
    function automatic logic [6:0] exp_digit(input int f, input int i);
        logic [27:0] v;
        for (int k = lq_cyc.size() - 1; k >= 0; k--) begin
            if (lq_cyc[k] / FRAME < f) begin
                v = lq_val[k];
                return v[i*7 +: 7];
            end
        end
        return 7'h00;
    endfunction

    function automatic logic exp_pend(input int c);
        if (c % FRAME == FRAME - 1) return 1'b0;
        for (int k = 0; k < lq_cyc.size(); k++) begin
            if (lq_cyc[k] / FRAME == c / FRAME && lq_cyc[k] <= c) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_ack(input int c);
        for (int k = 0; k < lq_cyc.size(); k++) begin
            if (lq_cyc[k] == c) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Record the inputs of every post-reset cycle; cyc = edges since release.
    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            lq_cyc.delete();
            lq_val.delete();
        end else begin
            if (cyc < 2048) dig_hist[cyc] = dig_en;
            if (load) begin
                lq_cyc.push_back(cyc);
                lq_val.push_back({cx4, cx3, cx2, cx1});
            end
            cyc = cyc + 1;
        end
    end

    always @(negedge clk) begin
        int c, pos, f, i, cn;
        logic [6:0] data, seg_e;
        logic [3:0] an_e;
        if (started) begin
            if (rst || cyc == 0) begin
                chk("rst_seg", seg, {7{~hi}});
                chk("rst_an", an, 4'hF);
                chk("rst_ack", load_ack, 1'b0);
                chk("rst_pend", upd_pend, 1'b0);
                chk("rst_fd", frame_done, 1'b0);
            end else begin
                c    = cyc - 1;
                pos  = c % FRAME;
                f    = c / FRAME;
                i    = pos / SD;
                cn   = pos % SD;
                data = (cn >= BC) ? exp_digit(f, i) : 7'h00;
                seg_e = data ^ {7{~hi}};
                an_e = 4'hF;
                if (cn >= BC && dig_hist[c][i]) an_e[i] = 1'b0;
                chk("seg", seg, seg_e);
                chk("an", an, an_e);
                chk("load_ack", load_ack, exp_ack(c));
                chk("upd_pend", upd_pend, exp_pend(c));
                chk("frame_done", frame_done, pos == FRAME - 1);
            end
        end
    end

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (1) begin
            @(posedge clk);
            #1;
            if (cyc >= k) break;
            guard++;
            if (guard > 4000) begin
                $display("FAIL wait_cyc timeout: cyc=%0d, needed %0d", cyc, k);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic do_load(input int c, input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] d, input logic [6:0] e);
        wait_cyc(c);
        cx1 = a; cx2 = b; cx3 = d; cx4 = e;
        load = 1'b1;
        wait_cyc(c + 1);
        load = 1'b0;
        chk("lit_load_ack", load_ack, 1'b1);
    endtask

    initial begin
        load = 1'b0; cx1 = '0; cx2 = '0; cx3 = '0; cx4 = '0;
        hi = 1'b1; dig_en = 4'hF;
        #1 rst = 1'b1;
        started = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        wait_cyc(2);  chk("lit_an_blank", an, 4'hF);
        wait_cyc(3);  chk("lit_an_d0", an, 4'hE);
        wait_cyc(11); chk("lit_an_d1", an, 4'hD);
        wait_cyc(31); chk("lit_fd_before", frame_done, 1'b0);
        wait_cyc(32); chk("lit_fd_first", frame_done, 1'b1);
        chk("lit_seg_zero", seg, 7'h00);

        do_load(40, 7'h06, 7'h5B, 7'h4F, 7'h66);
        chk("lit_pend_set", upd_pend, 1'b1);
        wait_cyc(59); chk("lit_old_frame", seg, 7'h00);
        wait_cyc(64); chk("lit_pend_clr", upd_pend, 1'b0);
        wait_cyc(67); chk("lit_d0_new", seg, 7'h06);
        wait_cyc(91); chk("lit_d3_new", seg, 7'h66);

        do_load(100, 7'h3F, 7'h5B, 7'h4F, 7'h66);
        do_load(110, 7'h7F, 7'h5B, 7'h4F, 7'h66);
        wait_cyc(131); chk("lit_latest_wins", seg, 7'h7F);

        do_load(159, 7'h6D, 7'h07, 7'h7D, 7'h71);
        chk("lit_bnd_pend", upd_pend, 1'b0);
        chk("lit_bnd_fd", frame_done, 1'b1);
        wait_cyc(163); chk("lit_bnd_data", seg, 7'h6D);

        do_load(170, 7'h06, 7'h07, 7'h7D, 7'h71);
        wait_cyc(180); hi = 1'b0;
        wait_cyc(193); chk("lit_lo_blank", seg, 7'h7F);
        wait_cyc(195); chk("lit_lo_drive", seg, 7'h79);
        wait_cyc(200); dig_en = 4'b1011;
        for (int k = 209; k <= 216; k++) begin
            wait_cyc(k);
            chk("lit_an2_off", an[2], 1'b1);
        end

        do_load(226, 7'h11, 7'h22, 7'h33, 7'h44);
        chk("lit_pend_pre_rst", upd_pend, 1'b1);
        wait_cyc(242);
        #1 rst = 1'b1;
        #1;
        chk("lit_rst_an", an, 4'hF);
        chk("lit_rst_seg", seg, 7'h7F);
        chk("lit_rst_pend", upd_pend, 1'b0);
        hi = 1'b1;
        dig_en = 4'hF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_cyc(3);  chk("lit_restart_an", an, 4'hE);
        chk("lit_restart_seg", seg, 7'h00);
        wait_cyc(40); chk("lit_restart_blankdata", seg, 7'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
